// File: rtl/mem_dump_unit_if.sv
// Control, memory-read and byte-stream signals of the memory dump engine.
// master = dump engine side, slave = host/memory side.
interface mem_dump_unit_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W:0]   words_sent;

    modport master (
        input  start, abort, base_addr, word_count, mem_rd_data, tx_ready,
        output busy, done, mem_rd_en, mem_addr, tx_data, tx_valid, words_sent
    );

    modport slave (
        output start, abort, base_addr, word_count, mem_rd_data, tx_ready,
        input  busy, done, mem_rd_en, mem_addr, tx_data, tx_valid, words_sent
    );
endinterface

// File: rtl/mem_dump_unit.sv
// Walks a word range of a sync-read memory and streams each word MSB-first as bytes.
// 6 cycles/word at full rate (READ, WAIT, 4 x SEND); tx_data held while tx_ready is low.
module mem_dump_unit #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_dump_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_W = 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   r_words_sent;
    logic [31:0]       r_shift;
    logic [1:0]        r_byte_cnt;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic              w_xfer;

    assign w_xfer = r_tx_valid & bus.tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_words_sent <= '0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort drops any partially sent word; words_sent keeps only whole words.
            if (r_state != S_IDLE && bus.abort) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_rd_en    <= 1'b0;
                r_tx_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_addr       <= bus.base_addr;
                            r_remaining  <= bus.word_count;
                            r_words_sent <= '0;
                            r_busy       <= 1'b1;
                            if (bus.word_count == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_READ;
                                r_rd_en <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        r_rd_en <= 1'b0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_shift    <= bus.mem_rd_data;
                        r_tx_data  <= bus.mem_rd_data[31:24];
                        r_tx_valid <= 1'b1;
                        r_byte_cnt <= '0;
                        r_state    <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_xfer) begin
                            if (r_byte_cnt == 2'd3) begin
                                r_tx_valid   <= 1'b0;
                                r_words_sent <= r_words_sent + ONE_W;
                                r_addr       <= r_addr + ONE_A;
                                r_remaining  <= r_remaining - ONE_W;
                                if (r_remaining == ONE_W) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_READ;
                                    r_rd_en <= 1'b1;
                                end
                            end else begin
                                r_shift    <= r_shift << 8;
                                r_tx_data  <= r_shift[23:16];
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.mem_rd_en  = r_rd_en;
    assign bus.mem_addr   = r_addr;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.words_sent = r_words_sent;
endmodule
